alu_nibble_sequencer: RTL

- Multi-cycle front end that drives the team's 4-bit ALU slice (4 x 1-bit ALUs plus CLA) to execute WIDTH-bit operations one nibble per cycle.
- Latches operands and op on a start handshake, then feeds one nibble per cycle from LSB to MSB, chaining the slice's cout into the next cin.
- Assembles the WIDTH-bit result and produces the zero flag, the carry-out and SLT handling.
- Sits between the execute-stage control and the single shared slice instance.

---
 rtl/alu_nibble_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/alu_nibble_sequencer.sv
// rtl/alu_nibble_sequencer.sv - drives a 4-bit ALU slice through WIDTH-bit ops one nibble per cycle
// Latches operands on start, chains slice carry LSB to MSB, assembles result and flags.
module alu_nibble_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic [3:0]       s_a,
   output logic [3:0]       s_b,
   output logic             s_cin,
   output logic             s_less,
   output logic [2:0]       s_op,
   input  logic [3:0]       s_result,
   input  logic             s_cout,
   input  logic             s_set
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = $clog2(NIB);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic [2:0]       op_reg;
   logic             last, accept, arith;
   logic [WIDTH-1:0] assembled, final_res;

   assign last   = (cnt == CW'(NIB - 1));
   assign accept = (state != RUN) && start;
   assign arith  = (op_reg == 3'b010) || (op_reg == 3'b110) || (op_reg == 3'b111);
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

   // Slice sees quiet operands whenever no operation is in flight
   assign s_a    = busy ? a_reg[4*cnt +: 4] : 4'h0;
   assign s_b    = busy ? b_reg[4*cnt +: 4] : 4'h0;
   assign s_cin  = busy ? carry : 1'b0;
   assign s_less = 1'b0;
   assign s_op   = op_reg;

   always_comb begin
      assembled = result;
      assembled[4*cnt +: 4] = s_result;
      // SLT takes the sign of A-B from the MSB nibble instead of the difference
      final_res = (op_reg == 3'b111) ? {{(WIDTH-1){1'b0}}, s_set} : assembled;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         carry  <= 1'b0;
         a_reg  <= '0;
         b_reg  <= '0;
         op_reg <= 3'b000;
         result <= '0;
         cout   <= 1'b0;
         zero   <= 1'b0;
      end else if (accept) begin
         a_reg  <= a;
         b_reg  <= b;
         op_reg <= op;
         cnt    <= '0;
         carry  <= op[2];
         result <= '0;
      end else if (busy) begin
         carry <= s_cout;
         cnt   <= cnt + 1'b1;
         if (last) begin
            result <= final_res;
            cout   <= arith & s_cout;
            zero   <= (final_res == '0);
         end else begin
            result <= assembled;
         end
      end
   end

endmodule
